// File: rtl/kbd_event_queue.sv
// Keyboard event queue: buffers {scan,ascii} press events from ps2_decoder, exposes
// DATA/STATUS registers on the CPU bus and raises an acknowledged interrupt while events wait.
module kbd_event_queue #(
  parameter int          DEPTH      = 8,
  parameter logic [63:0] BASE_ADDR  = 64'h2004,
  parameter logic [3:0]  IRQ_VEC    = 4'd1,
  parameter bit          ASCII_ONLY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  scan_code,
  input  logic [7:0]  ascii_code,
  input  logic        key_pressed,
  input  logic [63:0] bus_address,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  input  logic [63:0] bus_write_data,
  output logic [63:0] bus_read_data,
  output logic [3:0]  interrupt_vector,
  input  logic        interrupt_ack,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IRQ_IDLE     = 2'd0,
    IRQ_PENDING  = 2'd1,
    IRQ_SERVICED = 2'd2
  } irq_state_t;

  // Debug-visible FSM state for checkers bound to this block.
  irq_state_t irq_state;
  irq_state_t irq_next;

  logic          kp_q, rd_q, wr_q;
  logic          push_req;
  logic [15:0]   push_data;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    count8;
  logic          empty, full;
  logic          rd_pulse, wr_pulse, data_hit, stat_hit;
  logic          do_pop, do_push, ovf_set, ovf_clr, accept;
  logic          unused_wdata;

  // Bus strobes are levels from the slow CPU clock: only the first cycle of each
  // read/write acts; interrupt_ack is consumed only in PENDING.
  assign rd_pulse = bus_read_enable & ~rd_q;
  assign wr_pulse = bus_write_enable & ~wr_q;
  assign data_hit = (bus_address == BASE_ADDR);
  assign stat_hit = (bus_address == BASE_ADDR + 64'd8);

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign count8  = 8'(count);
  assign accept  = !(ASCII_ONLY && (ascii_code == 8'd0));
  assign do_pop  = rd_pulse & data_hit & ~empty;
  assign do_push = push_req & (~full | do_pop);
  assign ovf_set = push_req & full & ~do_pop;
  assign ovf_clr = wr_pulse & stat_hit & bus_write_data[1];

  assign unused_wdata = ^{bus_write_data[63:2], bus_write_data[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kp_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      push_req  <= 1'b0;
      push_data <= 16'd0;
    end else begin
      kp_q      <= key_pressed;
      rd_q      <= bus_read_enable;
      wr_q      <= bus_write_enable;
      push_req  <= key_pressed & ~kp_q & accept;
      push_data <= {scan_code, ascii_code};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_read_data <= 64'd0;
    end else if (rd_pulse && data_hit) begin
      bus_read_data <= empty ? 64'd0 : {32'd0, 1'b1, 15'd0, mem[rd_ptr]};
    end else if (rd_pulse && stat_hit) begin
      bus_read_data <= {48'd0, count8, 6'd0, overflow, ~empty};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_state <= IRQ_IDLE;
    else          irq_state <= irq_next;
  end

  always_comb begin
    irq_next = irq_state;
    case (irq_state)
      IRQ_IDLE:     if (!empty) irq_next = IRQ_PENDING;
      IRQ_PENDING:  if (empty) irq_next = IRQ_IDLE;
                    else if (interrupt_ack) irq_next = IRQ_SERVICED;
      IRQ_SERVICED: if (empty) irq_next = IRQ_IDLE;
      default:      irq_next = IRQ_IDLE;
    endcase
  end

  always_comb begin
    interrupt_vector = 4'd0;
    if (irq_state == IRQ_PENDING) interrupt_vector = IRQ_VEC;
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed scenarios then randomized traffic for kbd_event_queue, checked every cycle
// against a queue-based reference model.
module tb_kbd_event_queue;

  localparam int          DEPTH = 8;
  localparam logic [63:0] BASE  = 64'h2004;
  localparam logic [63:0] STAT  = 64'h200C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  scan_code, ascii_code;
  logic        key_pressed;
  logic [63:0] bus_address;
  logic        bus_read_enable, bus_write_enable;
  logic [63:0] bus_write_data;
  logic [63:0] bus_read_data;
  logic [3:0]  interrupt_vector;
  logic        interrupt_ack;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  kbd_event_queue dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .scan_code        (scan_code),
    .ascii_code       (ascii_code),
    .key_pressed      (key_pressed),
    .bus_address      (bus_address),
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_write_data   (bus_write_data),
    .bus_read_data    (bus_read_data),
    .interrupt_vector (interrupt_vector),
    .interrupt_ack    (interrupt_ack),
    .overflow         (overflow)
  );

  // Reference model state
  logic [15:0] exp_q[$];
  bit          m_pend;
  logic [15:0] m_pdata;
  bit          m_kp, m_rd, m_wr, m_ovf;
  bit          m_raised, m_serviced;
  logic [63:0] m_rdata;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pend = 0; m_pdata = 16'd0;
    m_kp = 0; m_rd = 0; m_wr = 0; m_ovf = 0;
    m_raised = 0; m_serviced = 0;
    m_rdata = 64'd0;
  endtask

  task automatic model_edge();
    bit nonempty, rp, wp, pop, push, drop;
    nonempty = (exp_q.size() != 0);
    if (m_raised) begin
      if (!nonempty) m_raised = 0;
      else if (interrupt_ack) begin m_raised = 0; m_serviced = 1; end
    end else if (m_serviced) begin
      if (!nonempty) m_serviced = 0;
    end else if (nonempty) begin
      m_raised = 1;
    end
    rp = bus_read_enable && !m_rd;
    wp = bus_write_enable && !m_wr;
    pop = 0; push = 0; drop = 0;
    if (rp && bus_address == BASE) begin
      if (nonempty) begin
        m_rdata = 64'h8000_0000 + 64'(exp_q[0]);
        pop = 1;
      end else begin
        m_rdata = 64'd0;
      end
    end else if (rp && bus_address == STAT) begin
      m_rdata = (64'(exp_q.size()) << 8) + (m_ovf ? 64'd2 : 64'd0) + (nonempty ? 64'd1 : 64'd0);
    end
    if (m_pend) begin
      if (exp_q.size() < DEPTH || pop) push = 1;
      else drop = 1;
    end
    if (wp && bus_address == STAT && bus_write_data[1]) m_ovf = 0;
    if (drop) m_ovf = 1;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(m_pdata);
    m_pend  = key_pressed && !m_kp && (ascii_code != 8'd0);
    m_pdata = {scan_code, ascii_code};
    m_kp = key_pressed; m_rd = bus_read_enable; m_wr = bus_write_enable;
  endtask

  task automatic check_outputs();
    check64("model_rdata", bus_read_data, m_rdata);
    check64("model_vector", 64'(interrupt_vector), m_raised ? 64'd1 : 64'd0);
    check64("model_overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    check_outputs();
  endtask

  task automatic press(input logic [7:0] s, input logic [7:0] a);
    scan_code = s; ascii_code = a; key_pressed = 1'b1;
    step();
    key_pressed = 1'b0;
    step();
  endtask

  task automatic bus_read(input logic [63:0] addr);
    bus_address = addr; bus_read_enable = 1'b1;
    step();
    bus_read_enable = 1'b0;
    step();
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
    bus_address = addr; bus_write_data = data; bus_write_enable = 1'b1;
    step();
    bus_write_enable = 1'b0;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    scan_code = 8'd0; ascii_code = 8'd0; key_pressed = 1'b0;
    bus_address = 64'd0; bus_read_enable = 1'b0; bus_write_enable = 1'b0;
    bus_write_data = 64'd0; interrupt_ack = 1'b0;
    model_reset();
    #1;
    check_outputs();
    step();
    step();
    reset_n = 1'b1;

    // 1: reset state, single press
    bus_read(STAT);
    check64("reset_status", bus_read_data, 64'd0);
    check64("reset_vector", 64'(interrupt_vector), 64'd0);
    press(8'h1C, 8'h61);
    step();
    check64("press_vector", 64'(interrupt_vector), 64'd1);
    bus_read(STAT);
    check64("press_status", bus_read_data, 64'h101);

    // 2: held read pops exactly once
    bus_address = BASE; bus_read_enable = 1'b1;
    for (int i = 0; i < 100; i++) step();
    bus_read_enable = 1'b0;
    step();
    check64("held_read_data", bus_read_data, 64'h8000_1C61);
    bus_read(STAT);
    check64("held_read_status", bus_read_data, 64'd0);
    bus_read(BASE);
    check64("empty_read", bus_read_data, 64'd0);

    // 3: overflow with pointer wrap
    for (int i = 0; i < 9; i++) press(8'h10 + 8'(i), 8'h41 + 8'(i));
    step();
    bus_read(STAT);
    check64("full_status", bus_read_data, 64'h803);
    check64("overflow_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE);
      check64("ordered_read", bus_read_data, 64'h8000_0000 + 64'({8'h10 + 8'(i), 8'h41 + 8'(i)}));
    end
    bus_write(STAT, 64'h2);
    check64("overflow_clear", 64'(overflow), 64'd0);

    // 4: push and pop in the same cycle on a full FIFO
    for (int i = 0; i < 8; i++) press(8'h20 + 8'(i), 8'h30 + 8'(i));
    step();
    scan_code = 8'h5A; ascii_code = 8'h0D; key_pressed = 1'b1;
    step();
    key_pressed = 1'b0; bus_address = BASE; bus_read_enable = 1'b1;
    step();
    bus_read_enable = 1'b0;
    step();
    check64("simul_pop_data", bus_read_data, 64'h8000_2030);
    bus_read(STAT);
    check64("simul_status", bus_read_data, 64'h801);
    check64("simul_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 8; i++) bus_read(BASE);
    check64("simul_last", bus_read_data, 64'h8000_5A0D);

    // 5: acknowledge handshake
    step();
    press(8'h32, 8'h62);
    step();
    check64("ack_pre_vector", 64'(interrupt_vector), 64'd1);
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
    step();
    check64("ack_vector", 64'(interrupt_vector), 64'd0);
    press(8'h21, 8'h63);
    step();
    check64("serviced_vector", 64'(interrupt_vector), 64'd0);
    bus_read(BASE);
    bus_read(BASE);
    step();
    press(8'h23, 8'h64);
    step();
    check64("rearm_vector", 64'(interrupt_vector), 64'd1);
    bus_read(BASE);
    step();

    // 6: zero-ascii filter and mid-queue reset
    press(8'h12, 8'h00);
    step();
    bus_read(STAT);
    check64("shift_dropped", bus_read_data, 64'd0);
    press(8'h1C, 8'h61);
    press(8'h32, 8'h62);
    press(8'h21, 8'h63);
    step();
    bus_read(STAT);
    check64("three_status", bus_read_data, 64'h301);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check64("mid_reset_vector", 64'(interrupt_vector), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    bus_read(STAT);
    check64("post_reset_status", bus_read_data, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      key_pressed = ($urandom_range(0, 2) == 0);
      scan_code = 8'($urandom_range(0, 255));
      ascii_code = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      bus_read_enable = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0, 1: bus_address = BASE;
        2:    bus_address = STAT;
        default: bus_address = BASE + 64'd16;
      endcase
      bus_write_enable = ($urandom_range(0, 9) == 0);
      bus_write_data = {32'($urandom), 32'($urandom)};
      interrupt_ack = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
